// File: rtl/risc16_pkg.sv
// risc16 shared definitions: opcodes, FSM states, instruction field positions.
// Imported by risc16_core_if, risc16_alu and risc16_core.
package risc16_pkg;

   localparam int DW = 16;

   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 9;
   localparam int RS_HI = 8;
   localparam int RS_LO = 6;
   localparam int RT_HI = 5;
   localparam int RT_LO = 3;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_OUT  = 4'hC;
   localparam logic [3:0] OP_MUL  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

endpackage

// File: rtl/risc16_core_if.sv
// External RAM load port of risc16_core.
// master: loader drives Ram_addr/Ram_data/WR_RAM_E; slave: core samples them.
interface risc16_core_if;
   import risc16_pkg::*;

   logic [DW-1:0] Ram_addr;
   logic [DW-1:0] Ram_data;
   logic          WR_RAM_E;

   modport master (output Ram_addr, output Ram_data, output WR_RAM_E);
   modport slave  (input Ram_addr, input Ram_data, input WR_RAM_E);

endinterface

// File: rtl/risc16_alu.sv
// risc16 combinational ALU: op_i/a_i/b_i -> y_o (ADD/SUB/AND/OR/XOR/ADDI).
// MUL path exists only when RISC16_MUL_EN is defined.
module risc16_alu
   import risc16_pkg::*;
(
   input  logic [3:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD,
         OP_ADDI: y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
`ifdef RISC16_MUL_EN
         OP_MUL:  y_o = a_i * b_i;
`endif
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/risc16_core.sv
// risc16 multicycle CPU with unified RAM loaded through ram_if while IDLE.
// Ports: CLK, rst_n, E (run), ram_if (load port), out_data, done. Macro: RISC16_MUL_EN.
module risc16_core
   import risc16_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          E,
   risc16_core_if.slave  ram_if,
   output logic [DW-1:0] out_data,
   output logic          done
);

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [DW-1:0]       ir_q;
   logic [DW-1:0]       out_q;
   logic                done_q;
   logic [DW-1:0]       rf_q [8];
   logic [DW-1:0]       mem_q [2**ADDR_W];

   logic [3:0]          op;
   logic [2:0]          rd, rs, rt;
   logic [DW-1:0]       rd_v, rs_v, rt_v;
   logic [DW-1:0]       simm, alu_b, alu_y, ea;
   logic [ADDR_W-1:0]   maddr;
   logic                alu_wb;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_wa;
   logic [DW-1:0]       ram_wd;

   assign op    = ir_q[OP_HI:OP_LO];
   assign rd    = ir_q[RD_HI:RD_LO];
   assign rs    = ir_q[RS_HI:RS_LO];
   assign rt    = ir_q[RT_HI:RT_LO];
   assign rd_v  = rf_q[rd];
   assign rs_v  = rf_q[rs];
   assign rt_v  = rf_q[rt];
   assign simm  = {{10{ir_q[5]}}, ir_q[5:0]};
   assign alu_b = (op == OP_ADDI) ? simm : rt_v;
   assign ea    = rs_v + simm;
   assign maddr = ea[ADDR_W-1:0];

   assign out_data = out_q;
   assign done     = done_q;

   risc16_alu u_alu (
      .op_i (op),
      .a_i  (rs_v),
      .b_i  (alu_b),
      .y_o  (alu_y)
   );

   always_comb begin
      alu_wb = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_XOR, OP_ADDI: alu_wb = 1'b1;
`ifdef RISC16_MUL_EN
         OP_MUL:                 alu_wb = 1'b1;
`endif
         default:                alu_wb = 1'b0;
      endcase
   end

   // Loader owns the RAM only in IDLE; ST owns it in MEM.
   always_comb begin
      ram_we = 1'b0;
      ram_wa = '0;
      ram_wd = '0;
      if (state_q == S_IDLE && ram_if.WR_RAM_E) begin
         ram_we = 1'b1;
         ram_wa = ram_if.Ram_addr[ADDR_W-1:0];
         ram_wd = ram_if.Ram_data;
      end else if (state_q == S_MEM && E && op == OP_ST) begin
         ram_we = 1'b1;
         ram_wa = maddr;
         ram_wd = rd_v;
      end
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (ram_we) mem_q[ram_wa] <= ram_wd;
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (E) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (E) begin
                  ir_q    <= mem_q[pc_q];
                  pc_q    <= pc_q + ADDR_W'(1);
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (E) begin
                  state_q <= S_FETCH;
                  if (alu_wb) rf_q[rd] <= alu_y;
                  if (op == OP_LDI) rf_q[rd] <= {8'h00, ir_q[7:0]};
                  if (op == OP_BEQ && rd_v == rs_v)
                     pc_q <= pc_q + simm[ADDR_W-1:0];
                  if (op == OP_JMP) pc_q <= ADDR_W'(ir_q[11:0]);
                  if (op == OP_OUT) out_q <= rd_v;
                  if (op == OP_LD || op == OP_ST) state_q <= S_MEM;
                  if (op == OP_HALT) begin
                     state_q <= S_HALT;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_MEM: begin
               if (E) begin
                  if (op == OP_LD) rf_q[rd] <= mem_q[maddr];
                  state_q <= S_FETCH;
               end
            end
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_risc16_core.sv
// Self-checking bench for risc16_core: directed and random programs
// compared edge-by-edge against an instruction-level reference model.
module tb_risc16_core;
   import risc16_pkg::*;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        E = 1'b0;
   logic [15:0] out_data;
   logic        done;

   risc16_core_if ram_if ();

   risc16_core #(.ADDR_W(8)) u_dut (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .E        (E),
      .ram_if   (ram_if),
      .out_data (out_data),
      .done     (done)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   logic [15:0] prog [$];
   logic [15:0] img [256];
   logic [15:0] mm  [256];
   logic [15:0] mr  [8];
   int          ev_e [$];
   logic [15:0] ev_v [$];
   int          m_halt;

   task automatic build_img();
      for (int a = 0; a < 256; a++)
         img[a] = (a < prog.size()) ? prog[a] : 16'($urandom);
   endtask

   // Instruction-level model; t counts active edges after E is first sampled.
   task automatic model_run();
      int pc, t, rd, rs, rt, s, op;
      logic [15:0] ir, a, b;
      bit stop;
      mm = img;
      foreach (mr[i]) mr[i] = '0;
      ev_e.delete();
      ev_v.delete();
      m_halt = -1;
      pc = 0;
      t = 0;
      stop = 0;
      for (int st = 0; st < 3000 && !stop; st++) begin
         ir = mm[pc];
         pc = (pc + 1) % 256;
         op = int'(ir[15:12]);
         rd = int'(ir[11:9]);
         rs = int'(ir[8:6]);
         rt = int'(ir[5:3]);
         s  = int'($signed(ir[5:0]));
         a  = mr[rs];
         b  = mr[rt];
         case (op)
            1:  mr[rd] = a + b;
            2:  mr[rd] = a - b;
            3:  mr[rd] = a & b;
            4:  mr[rd] = a | b;
            5:  mr[rd] = a ^ b;
            6:  mr[rd] = a + 16'(s);
            7:  mr[rd] = {8'h00, ir[7:0]};
            8:  mr[rd] = mm[(int'(a) + s) & 255];
            9:  mm[(int'(a) + s) & 255] = mr[rd];
            10: if (mr[rd] == a) pc = (pc + s) & 255;
            11: pc = int'(ir[11:0]) & 255;
            12: begin
               ev_e.push_back(t + 2);
               ev_v.push_back(mr[rd]);
            end
`ifdef RISC16_MUL_EN
            13: mr[rd] = a * b;
`endif
            15: begin
               m_halt = t + 2;
               stop = 1;
            end
            default: ;
         endcase
         t += (op == 8 || op == 9) ? 3 : 2;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      rst_n = 1'b0;
      E = 1'b0;
      ram_if.WR_RAM_E = 1'b0;
      @(negedge CLK);
      rst_n = 1'b1;
   endtask

   task automatic load_img();
      for (int a = 0; a < 256; a++) begin
         ram_if.Ram_addr = {8'($urandom), 8'(a)};
         ram_if.Ram_data = img[a];
         ram_if.WR_RAM_E = 1'b1;
         @(negedge CLK);
      end
      ram_if.WR_RAM_E = 1'b0;
   endtask

   task automatic run_img(string tag, bit pause);
      int k, hold;
      logic [15:0] eo;
      bit ed, fin;
      do_reset();
      load_img();
      model_run();
      E = 1'b1;
      k = -1;
      hold = 0;
      fin = 0;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         @(negedge CLK);
         if (E) k++;
         eo = '0;
         foreach (ev_e[i]) if (ev_e[i] <= k) eo = ev_v[i];
         ed = (m_halt >= 0) && (k >= m_halt);
         chk({tag, "_out"}, 32'(out_data), 32'(eo));
         chk({tag, "_done"}, 32'(done), 32'(ed));
         fin = (m_halt >= 0) && (k >= m_halt + 3);
         ram_if.WR_RAM_E = 1'b0;
         if (pause) begin
            if (hold > 0) begin
               hold--;
               if (hold == 0) E = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
               E = 1'b0;
               hold = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 2) == 0) begin
               ram_if.Ram_addr = 16'($urandom_range(0, 7));
               ram_if.Ram_data = 16'($urandom);
               ram_if.WR_RAM_E = 1'b1;
            end
         end
      end
      ram_if.WR_RAM_E = 1'b0;
      E = 1'b0;
      if (!fin) chk({tag, "_timeout"}, 32'(k), 32'(m_halt + 3));
      for (int a = 0; a < 256; a++)
         chk({tag, "_mem"}, 32'(u_dut.mem_q[a]), 32'(mm[a]));
   endtask

   task automatic gen_rand();
      int n, op;
      int ops [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 9, 12, 12, 13, 14};
      logic [15:0] w;
      n = $urandom_range(4, 30);
      prog.delete();
      for (int i = 0; i < n; i++) begin
         op = ops[$urandom_range(0, 14)];
         case (op)
            7:  w = {4'h7, 3'($urandom_range(1, 7)), 1'b0, 8'($urandom)};
            8, 9: w = {4'(op), 3'($urandom_range(1, 7)), 3'd0,
                       6'($urandom_range(32, 63))};
            12: w = {4'hC, 3'($urandom_range(0, 7)), 9'($urandom)};
            default: w = {4'(op), 3'($urandom_range(1, 7)),
                          3'($urandom), 6'($urandom)};
         endcase
         prog.push_back(w);
      end
      prog.push_back(16'hF000);
      build_img();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ram_if.Ram_addr = '0;
      ram_if.Ram_data = '0;
      ram_if.WR_RAM_E = 1'b0;
      #1;
      chk("rst_out", 32'(out_data), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_pc", 32'(u_dut.pc_q), 32'h0);
      chk("rst_ir", 32'(u_dut.ir_q), 32'h0);
      do_reset();
      repeat (4) @(negedge CLK);
      chk("idle_hold", 32'(u_dut.state_q), 32'(S_IDLE));

      prog = '{16'h7205, 16'h7407, 16'h1650, 16'hC600, 16'hF000};
      build_img();
      run_img("tp_add", 0);
      chk("tp_add_final", 32'(out_data), 32'h000C);

      prog = '{16'h7200, 16'h7401, 16'h2650, 16'hC600, 16'hF000};
      build_img();
      run_img("tp_sub", 0);
      chk("tp_sub_final", 32'(out_data), 32'hFFFF);

      prog = '{16'h7255, 16'h7480, 16'h9280, 16'h8880, 16'hC800, 16'hF000};
      build_img();
      run_img("tp_ldst", 0);
      chk("tp_ldst_final", 32'(out_data), 32'h0055);
      chk("tp_ldst_ram", 32'(u_dut.mem_q[8'h80]), 32'h0055);

      prog = '{16'h7203, 16'hC200, 16'h627F, 16'hA201, 16'hB001, 16'hF000};
      build_img();
      run_img("tp_loop", 0);
      chk("tp_loop_final", 32'(out_data), 32'h0001);
      run_img("tp_loop_pause", 1);

      // Asynchronous reset mid-run
      do_reset();
      load_img();
      E = 1'b1;
      repeat (7) @(negedge CLK);
      rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(u_dut.state_q), 32'(S_IDLE));
      chk("midrst_out", 32'(out_data), 32'h0);
      chk("midrst_pc", 32'(u_dut.pc_q), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      E = 1'b0;
      @(negedge CLK);
      rst_n = 1'b1;

      for (int r = 0; r < 8; r++) begin
         gen_rand();
         run_img("rnd", 0);
      end
      for (int r = 0; r < 8; r++) begin
         gen_rand();
         run_img("rnd_pause", 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/risc16_core.md
# risc16_core

Multicycle 16-bit load/store CPU with an internal unified instruction/data RAM. The RAM is loaded through an external write port while the core is idle. When enabled, the core runs from address 0 until it executes HALT. It drives a 16-bit output register (`out_data`) and a `done` flag. It is the top-level processor block of the design.

## Interface
- `ADDR_W`, default 8: RAM address width; depth is 2^ADDR_W words of 16 bits.
- `CLK` in 1: single clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `E` in 1: run enable. 1 = execute; 0 = idle/paused.
- `Ram_addr` in 16: external RAM write address; only the low ADDR_W bits are used.
- `Ram_data` in 16: external RAM write data.
- `WR_RAM_E` in 1: external RAM write strobe.
- `out_data` out 16: value of the last OUT instruction.
- `done` out 1: high after HALT executes; sticky until reset.

## Operation
- State: R0–R7 (16 bits each), PC (ADDR_W bits), IR (16 bits), RAM array.
- RAM reads are combinational; RAM writes are synchronous.
- Instruction fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm6=[5:0] (sign-extended), imm8=[7:0] (zero-extended), imm12=[11:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs+rt.
  - 2 SUB: rd=rs−rt.
  - 3 AND: rd=rs&rt.
  - 4 OR: rd=rs|rt.
  - 5 XOR: rd=rs^rt.
  - 6 ADDI: rd=rs+imm6.
  - 7 LDI: rd=imm8.
  - 8 LD: rd=RAM[rs+imm6].
  - 9 ST: RAM[rs+imm6]=rd.
  - A BEQ: if rd==rs, PC=PC+imm6 (PC already incremented).
  - B JMP: PC=imm12.
  - C OUT: out_data=rd.
  - D MUL: see Configuration.
  - E: treated as NOP.
  - F HALT.
- Arithmetic is modulo 2^16; carries and overflow are discarded. No flags register.
- Memory addresses and PC are truncated to ADDR_W bits and wrap around.
- FSM states:
  - IDLE: external writes enabled.
  - FETCH: IR←RAM[PC], PC←PC+1.
  - EXEC: ALU, register writeback, branch, OUT, HALT.
  - MEM: LD/ST access.
  - HALT: terminal.
- Transitions:
  - IDLE→FETCH when E=1.
  - FETCH→EXEC.
  - EXEC→MEM for LD/ST; EXEC→HALT for HALT; otherwise EXEC→FETCH.
  - MEM→FETCH.
  - HALT stays in HALT.
- E=0 in any non-IDLE, non-HALT state freezes the FSM and all registers; execution resumes unchanged when E returns to 1.
- External write (RAM[Ram_addr]←Ram_data) happens only when WR_RAM_E=1 and state is IDLE. It is ignored in all other states.

## Timing
- Reset values: out_data=0, done=0, PC=0, IR=0, R0–R7=0, state=IDLE. RAM contents are not reset.
- Reset asserted mid-run returns the core to IDLE immediately.
- Latency: 2 cycles per instruction, 3 cycles for LD/ST.
- With E=1 sampled in IDLE at edge n:
  - The first FETCH occurs at edge n+1.
  - The first EXEC occurs at edge n+2.
- out_data updates on the EXEC edge of OUT. done rises on the EXEC edge of HALT.
- Register writes take effect at the end of EXEC (or MEM for LD) and are visible to the next instruction.
- ST followed by LD to the same address returns the stored value.

## Configuration
- `RISC16_MUL_EN` defined: opcode D is MUL, rd=low 16 bits of rs*rt, single-cycle in EXEC.
- Without the macro: opcode D executes as NOP, with no multiplier hardware.

## Structure
- Package `risc16_pkg`:
  - opcode localparams;
  - FSM state enum;
  - field-position constants;
  - data-width constant 16.
- Sub-module `risc16_alu`: combinational op/a/b→result for ADD/SUB/AND/OR/XOR/ADDI/MUL, with the MUL path guarded by the macro.
- Register file, RAM, and FSM stay in the top module.

## Test plan
- Reset → out_data=0x0000, done=0. Hold E=0 → state remains IDLE.
- Load 0:7205, 1:7407, 2:1650, 3:C600, 4:F000, then raise E → out_data=0x000C on the 8th edge after E is sampled, done=1 two edges later, and stays high.
- LDI R1,0 (7200); LDI R2,1 (7401); SUB R3,R1,R2 (2650); OUT R3 (C600); HALT → out_data=0xFFFF.
- LDI R1,0x55; LDI R2,0x80; ST R1,[R2+0]; LD R4,[R2+0]; OUT R4; HALT → out_data=0x0055, and RAM[0x80]=0x0055.
- Countdown loop: R1=3, then OUT R1; ADDI R1,R1,−1; BEQ R1,R0 exit; JMP loop → out_data sequence 3,2,1, then done=1.
- WR_RAM_E pulse to an executing address while running → no RAM change, program output unaffected; E=0 mid-run freezes out_data/PC, and resumption produces identical results.
